mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter between instruction fetch and data access
// One access at a time; DM wins ties unless IF already lost the previous tie.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_abort_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  output logic        if_stall_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        dm_stall_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        if_starved;
  logic        gnt_if;
  logic        aborted;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        grant;
  logic        pick_dm;
  logic        abort_now;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = if_req_i | dm_req_i;
    pick_dm    = dm_req_i & ~(if_req_i & if_starved);
    abort_now  = gnt_if & if_abort_i;
    if_ready_o = 1'b0;
    dm_ready_o = 1'b0;
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    case (state)
      IDLE: if (grant) state_nxt = ACC;
      ACC: begin
        mem_en_o = 1'b1;
        mem_we_o = cap_we;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        // an abort seen in ACC or in this very cycle suppresses the fetch pulse
        if_ready_o = gnt_if & ~aborted & ~if_abort_i;
        dm_ready_o = ~gnt_if;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_stall_o  = if_req_i & ~if_ready_o;
  assign dm_stall_o  = dm_req_i & ~dm_ready_o;
  assign mem_addr_o  = cap_addr;
  assign mem_wdata_o = cap_wdata;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      if_starved <= 1'b0;
      gnt_if     <= 1'b0;
      aborted    <= 1'b0;
      cap_we     <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      if_data_o  <= 32'd0;
      dm_rdata_o <= 32'd0;
    end else begin
      if (state == IDLE && grant) begin
        gnt_if     <= ~pick_dm;
        if_starved <= pick_dm & if_req_i;
        cap_we     <= pick_dm & dm_we_i;
        cap_addr   <= pick_dm ? dm_addr_i : if_addr_i;
        cap_wdata  <= pick_dm ? dm_wdata_i : 32'd0;
        cnt        <= 4'(LAT - 1);
        aborted    <= 1'b0;
      end
      if (state == ACC) begin
        if (abort_now) aborted <= 1'b1;
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (gnt_if) begin
          if (!aborted && !if_abort_i) if_data_o <= mem_rdata_i;
        end else if (!cap_we) begin
          dm_rdata_o <= mem_rdata_i;
        end
      end
    end
  end

endmodule
